// File: rtl/cache_ctrl_4way.sv
// 4-way set-associative write-back/write-allocate cache controller, one 32-bit word per line.
// Latency: hit 2 cycles from accept to cpu_ready; miss adds refill (and write-back) round trips.
// Backpressure: one request in flight; cpu_req ignored outside IDLE; mem_req held until mem_ack.
// Optional build macro CACHE_STATS_EN adds saturating hit_cnt/miss_cnt outputs.
module cache_ctrl_4way #(
    parameter int SETS  = 256,
    parameter int TAG_W = 22
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
`ifdef CACHE_STATS_EN
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt,
`endif
    input  logic        mem_ack
);

    localparam int IDX_W = $clog2(SETS);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOOKUP    = 3'd1,
        WRITEBACK = 3'd2,
        REFILL    = 3'd3,
        RESPOND   = 3'd4
    } state_t;

    state_t state, nstate;

    // Latched request (byte offset dropped, it never affects the word-sized line)
    logic              req_we;
    logic [29:0]       req_word;
    logic [31:0]       req_wdata;
    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  idx;
    logic              unused_addr_bits;

    assign req_tag          = req_word[29 -: TAG_W];
    assign idx              = req_word[IDX_W-1:0];
    assign unused_addr_bits = ^cpu_addr[1:0];

    // Cache state arrays
    logic [TAG_W-1:0] tag_arr   [SETS][4];
    logic [31:0]      data_arr  [SETS][4];
    logic [3:0]       valid_arr [SETS];
    logic [3:0]       dirty_arr [SETS];
    logic [2:0]       plru_arr  [SETS];   // [0]=b0 (root), [1]=b1 (ways 0/1), [2]=b2 (ways 2/3)

    // Way the current miss is being serviced into (captured in LOOKUP)
    logic [1:0] acc_way;

    logic [3:0] hit_vec;
    logic       hit;
    logic [1:0] hit_way;
    logic [1:0] victim_way;
    logic       victim_dirty;
    logic [1:0] way_sel;
    logic       mem_fire;

    assign mem_fire = mem_req && mem_ack;

    // Tree-PLRU update: point the tree away from the way just touched
    function automatic logic [2:0] plru_next(input logic [2:0] p, input logic [1:0] w);
        logic [2:0] r;
        r    = p;
        r[0] = ~w[1];
        if (!w[1]) r[1] = (w == 2'd0);
        else       r[2] = (w == 2'd2);
        return r;
    endfunction

    // Tag compare, hit way, and victim choice for the latched set
    always_comb begin
        hit_vec      = '0;
        hit_way      = 2'd0;
        victim_way   = 2'd0;
        victim_dirty = 1'b0;
        for (int w = 0; w < 4; w++) begin
            hit_vec[w] = valid_arr[idx][w] && (tag_arr[idx][w] == req_tag);
        end
        for (int w = 3; w >= 0; w--) begin
            if (hit_vec[w]) hit_way = 2'(w);
        end
        if (&valid_arr[idx]) begin
            if (!plru_arr[idx][0]) victim_way = plru_arr[idx][1] ? 2'd1 : 2'd0;
            else                   victim_way = plru_arr[idx][2] ? 2'd3 : 2'd2;
        end else begin
            for (int w = 3; w >= 0; w--) begin
                if (!valid_arr[idx][w]) victim_way = 2'(w);
            end
        end
        victim_dirty = valid_arr[idx][victim_way] && dirty_arr[idx][victim_way];
    end

    assign hit     = |hit_vec;
    assign way_sel = (state == LOOKUP) ? (hit ? hit_way : victim_way) : acc_way;

    // Next-state logic
    always_comb begin
        nstate = state;
        case (state)
            IDLE:      if (cpu_req) nstate = LOOKUP;
            LOOKUP: begin
                if (hit)               nstate = RESPOND;
                else if (victim_dirty) nstate = WRITEBACK;
                else                   nstate = REFILL;
            end
            WRITEBACK: if (mem_fire) nstate = REFILL;
            REFILL:    if (mem_fire) nstate = RESPOND;
            RESPOND:   nstate = IDLE;
            default:   nstate = IDLE;
        endcase
    end

    // State register, request latch, and registered CPU/memory port outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            req_we    <= 1'b0;
            req_word  <= '0;
            req_wdata <= '0;
            acc_way   <= 2'd0;
            cpu_ready <= 1'b0;
            cpu_rdata <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state <= nstate;
            if (state == IDLE && cpu_req) begin
                req_we    <= cpu_we;
                req_word  <= cpu_addr[31:2];
                req_wdata <= cpu_wdata;
            end
            if (state == LOOKUP) acc_way <= way_sel;
            // Request drops for one cycle after every ack, including WRITEBACK->REFILL
            mem_req   <= (nstate == WRITEBACK || nstate == REFILL) && !mem_fire;
            mem_we    <= (nstate == WRITEBACK);
            if (nstate == WRITEBACK) begin
                mem_addr  <= {tag_arr[idx][way_sel], idx, 2'b00};
                mem_wdata <= data_arr[idx][way_sel];
            end else if (nstate == REFILL) begin
                mem_addr  <= {req_word, 2'b00};
                mem_wdata <= '0;
            end else begin
                mem_addr  <= '0;
                mem_wdata <= '0;
            end
            cpu_ready <= (nstate == RESPOND);
            if (nstate == RESPOND && state != RESPOND) begin
                if (req_we)               cpu_rdata <= req_wdata;
                else if (state == LOOKUP) cpu_rdata <= data_arr[idx][hit_way];
                else                      cpu_rdata <= mem_rdata;
            end
        end
    end

    // Valid/dirty/PLRU bookkeeping; cleared by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < SETS; s++) begin
                valid_arr[s] <= '0;
                dirty_arr[s] <= '0;
                plru_arr[s]  <= '0;
            end
        end else begin
            if (state == LOOKUP && hit) begin
                plru_arr[idx] <= plru_next(plru_arr[idx], hit_way);
            end
            if (state == REFILL && mem_fire) begin
                valid_arr[idx][acc_way] <= 1'b1;
                dirty_arr[idx][acc_way] <= 1'b0;
                plru_arr[idx]           <= plru_next(plru_arr[idx], acc_way);
            end
            if (state == RESPOND && req_we) begin
                dirty_arr[idx][acc_way] <= 1'b1;
            end
        end
    end

    // Tag and data storage; contents are meaningless until valid, so no reset, only a hold
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == REFILL && mem_fire) begin
                tag_arr[idx][acc_way]  <= req_tag;
                data_arr[idx][acc_way] <= mem_rdata;
            end
            if (state == RESPOND && req_we) begin
                data_arr[idx][acc_way] <= req_wdata;
            end
        end
    end

`ifdef CACHE_STATS_EN
    // Saturating hit/miss counters, one count per LOOKUP outcome
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (state == LOOKUP) begin
            if (hit) begin
                if (hit_cnt != 32'hFFFF_FFFF) hit_cnt <= hit_cnt + 32'd1;
            end else begin
                if (miss_cnt != 32'hFFFF_FFFF) miss_cnt <= miss_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
